// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-memory port between the CPU and a debug master.
// Define ARB_ROUND_ROBIN_EN for round-robin resolution of unlocked conflicts; the default build is fixed CPU priority.
module data_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 12,
    parameter int MAX_HOLD = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic          o_cpu_stall,
    output logic          o_cpu_rvalid,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic          i_dbg_lock,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic          o_dbg_gnt,
    output logic          o_dbg_rvalid,
    output logic [DW-1:0] o_dbg_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED} state_t;
    state_t        r_state;
    logic          r_last;
    logic [HW-1:0] r_hold;
    logic          r_ovr;
    logic          r_cpu_rd;
    logic          r_dbg_rd;
    logic          w_both;
    logic          w_ovr;
    logic          w_lk;
    logic          w_pol;
    logic          w_dbg_gnt;
    logic          w_cpu_gnt;
    assign w_both = i_cpu_req & i_dbg_req;
    assign w_ovr  = w_both & (r_hold == HW'(MAX_HOLD));
    // r_ovr lets a still-locked debug master reclaim the port right after a forced CPU slot
    assign w_lk   = w_both & ~w_ovr & i_dbg_lock & ((r_state == DBG_LOCKED) | r_ovr);
`ifdef ARB_ROUND_ROBIN_EN
    assign w_pol  = ~r_last;
`else
    assign w_pol  = 1'b0;
`endif
    assign w_dbg_gnt = ~i_reset & i_dbg_req & (~i_cpu_req | (~w_ovr & (w_lk | w_pol)));
    assign w_cpu_gnt = ~i_reset & i_cpu_req & ~w_dbg_gnt;
    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_dbg_gnt    = w_dbg_gnt;
    assign o_cpu_stall  = i_cpu_req & ~w_cpu_gnt;
    assign o_mem_addr   = w_dbg_gnt ? i_dbg_addr : i_cpu_addr;
    assign o_mem_wdata  = w_dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
    assign o_mem_we     = w_dbg_gnt ? i_dbg_we : (w_cpu_gnt & i_cpu_we);
    assign o_cpu_rvalid = r_cpu_rd & ~i_reset;
    assign o_dbg_rvalid = r_dbg_rd & ~i_reset;
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
    assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : '0;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_last   <= 1'b0;
            r_hold   <= '0;
            r_ovr    <= 1'b0;
            r_cpu_rd <= 1'b0;
            r_dbg_rd <= 1'b0;
        end else begin
            r_state  <= w_cpu_gnt ? CPU_OWN : w_dbg_gnt ? (i_dbg_lock ? DBG_LOCKED : DBG_OWN) : IDLE;
            r_last   <= w_dbg_gnt ? 1'b1 : w_cpu_gnt ? 1'b0 : r_last;
            r_hold   <= (~i_cpu_req | w_cpu_gnt) ? '0 : w_lk ? r_hold + 1'b1 : r_hold;
            r_ovr    <= w_ovr;
            r_cpu_rd <= w_cpu_gnt & ~i_cpu_we;
            r_dbg_rd <= w_dbg_gnt & ~i_dbg_we;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed tests of data_mem_arbiter against a 1-cycle synchronous memory model.
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [11:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
    logic [11:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [11:0] mem [0:4095];
    int passed = 0;
    int total  = 0;
    data_mem_arbiter dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_lock(dbg_lock), .i_dbg_addr(dbg_addr),
        .i_dbg_wdata(dbg_wdata), .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask
    task automatic test_reset();
        reset = 1; idle();
        cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
        tick(); #3;
        total++; if ({cpu_gnt, dbg_gnt, mem_we} !== 3'b000) $display("FAIL reset_gnt gnt/we=%b exp 000", {cpu_gnt, dbg_gnt, mem_we}); else passed++;
        total++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) $display("FAIL reset_rvalid rvalid=%b exp 00", {cpu_rvalid, dbg_rvalid}); else passed++;
        tick(); reset = 0; idle(); tick();
        total++; if (dut.r_state !== 2'd0) $display("FAIL reset_state state=%0d exp 0", dut.r_state); else passed++;
        total++; if (dut.r_last !== 1'b0) $display("FAIL reset_last last_owner=%0d exp 0", dut.r_last); else passed++;
    endtask
    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_wdata = 12'hABC; #3;
        total++; if ({cpu_gnt, mem_we, mem_addr} !== {2'b11, 12'h040}) $display("FAIL cpu_wr gnt=%b we=%b addr=%h exp 1 1 040", cpu_gnt, mem_we, mem_addr); else passed++;
        tick(); cpu_we = 0; #3;
        total++; if ({cpu_gnt, mem_we} !== 2'b10) $display("FAIL cpu_rd_gnt gnt=%b we=%b exp 1 0", cpu_gnt, mem_we); else passed++;
        tick(); idle();
        total++; if ({cpu_rvalid, cpu_rdata, dbg_rvalid} !== {1'b1, 12'hABC, 1'b0}) $display("FAIL cpu_rd_ret rvalid=%b rdata=%h dbg_rvalid=%b exp 1 abc 0", cpu_rvalid, cpu_rdata, dbg_rvalid); else passed++;
        tick();
        total++; if ({cpu_rvalid, cpu_rdata} !== 13'h0) $display("FAIL cpu_rd_end rvalid=%b rdata=%h exp 0 000", cpu_rvalid, cpu_rdata); else passed++;
    endtask
    task automatic test_conflict();
        logic dbg_first;
`ifdef ARB_ROUND_ROBIN_EN
        dbg_first = 1'b1;
`else
        dbg_first = 1'b0;
`endif
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 12'h111;
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h020; dbg_wdata = 12'h222; #3;
        total++; if ({cpu_gnt, dbg_gnt, cpu_stall} !== {~dbg_first, dbg_first, dbg_first}) $display("FAIL conf_first cpu_gnt=%b dbg_gnt=%b stall=%b exp %b %b %b", cpu_gnt, dbg_gnt, cpu_stall, ~dbg_first, dbg_first, dbg_first); else passed++;
        total++; if ({mem_we, mem_addr, mem_wdata} !== (dbg_first ? {1'b1, 12'h020, 12'h222} : {1'b1, 12'h010, 12'h111})) $display("FAIL conf_bus we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata); else passed++;
        tick();
        if (dbg_first) dbg_req = 0; else cpu_req = 0;
        #3;
        total++; if ({cpu_gnt, dbg_gnt, cpu_stall} !== {dbg_first, ~dbg_first, 1'b0}) $display("FAIL conf_second cpu_gnt=%b dbg_gnt=%b stall=%b exp %b %b 0", cpu_gnt, dbg_gnt, cpu_stall, dbg_first, ~dbg_first); else passed++;
        total++; if (mem_addr !== (dbg_first ? 12'h010 : 12'h020)) $display("FAIL conf_addr2 addr=%h", mem_addr); else passed++;
        tick(); idle();
    endtask
    task automatic test_alternating_reads();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h001; cpu_wdata = 12'h123; tick(); idle();
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h002; dbg_wdata = 12'h456; tick(); idle();
        cpu_req = 1; cpu_addr = 12'h001; tick(); idle();
        dbg_req = 1; dbg_addr = 12'h002; #3;
        total++; if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b1, 12'h123, 1'b0, 12'h000}) $display("FAIL alt_cpu1 c=%b %h d=%b %h exp 1 123 0 000", cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata); else passed++;
        tick(); idle();
        cpu_req = 1; cpu_addr = 12'h010; #3;
        total++; if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b0, 12'h000, 1'b1, 12'h456}) $display("FAIL alt_dbg1 c=%b %h d=%b %h exp 0 000 1 456", cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata); else passed++;
        tick(); idle();
        dbg_req = 1; dbg_addr = 12'h020; #3;
        total++; if ({cpu_rvalid, cpu_rdata, dbg_rvalid} !== {1'b1, 12'h111, 1'b0}) $display("FAIL alt_cpu2 c=%b %h d=%b exp 1 111 0", cpu_rvalid, cpu_rdata, dbg_rvalid); else passed++;
        tick(); idle();
        total++; if ({cpu_rvalid, dbg_rvalid, dbg_rdata} !== {2'b01, 12'h222}) $display("FAIL alt_dbg2 c=%b d=%b %h exp 0 1 222", cpu_rvalid, dbg_rvalid, dbg_rdata); else passed++;
        tick();
    endtask
    task automatic test_lock_burst();
        int stalls = 0;
        dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 12'h100; dbg_wdata = 12'h5A5; #3;
        total++; if (dbg_gnt !== 1'b1) $display("FAIL lock_take dbg_gnt=%b exp 1", dbg_gnt); else passed++;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h040;
        for (int i = 1; i <= 8; i++) begin
            #3;
            stalls += int'(cpu_stall);
            total++; if ({dbg_gnt, cpu_gnt} !== 2'b10) $display("FAIL lock_hold%0d dbg_gnt=%b cpu_gnt=%b exp 1 0", i, dbg_gnt, cpu_gnt); else passed++;
            tick();
        end
        #3;
        stalls += int'(cpu_stall);
        total++; if ({cpu_gnt, dbg_gnt} !== 2'b10) $display("FAIL lock_guard cpu_gnt=%b dbg_gnt=%b exp 1 0", cpu_gnt, dbg_gnt); else passed++;
        total++; if (stalls !== 8) $display("FAIL lock_stalls stall_cycles=%0d exp 8", stalls); else passed++;
        tick();
        cpu_addr = 12'h001; #3;
        total++; if ({dbg_gnt, cpu_stall} !== 2'b11) $display("FAIL lock_resume dbg_gnt=%b stall=%b exp 1 1", dbg_gnt, cpu_stall); else passed++;
        total++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 12'hABC}) $display("FAIL lock_cpu_ret rvalid=%b rdata=%h exp 1 abc", cpu_rvalid, cpu_rdata); else passed++;
        tick(); idle(); tick();
    endtask
    task automatic test_reset_mid_read();
        dbg_req = 1; dbg_addr = 12'h002; #3;
        total++; if (dbg_gnt !== 1'b1) $display("FAIL rmr_gnt dbg_gnt=%b exp 1", dbg_gnt); else passed++;
        tick(); idle(); reset = 1; #3;
        total++; if ({dbg_rvalid, dbg_rdata} !== 13'h0) $display("FAIL rmr_rvalid rvalid=%b rdata=%h exp 0 000", dbg_rvalid, dbg_rdata); else passed++;
        tick(); reset = 0;
        total++; if (dut.r_state !== 2'd0 || dbg_rvalid !== 1'b0) $display("FAIL rmr_state state=%0d rvalid=%b exp 0 0", dut.r_state, dbg_rvalid); else passed++;
        tick();
    endtask
    initial begin
        mem_rdata = '0;
        test_reset();
        test_cpu_read();
        test_conflict();
        test_alternating_reads();
        test_lock_burst();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
